// File: rtl/axi4_lite_cmd_mst_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axi4_lite_cmd_mst_pkg;

  localparam int unsigned STATE_BIT_WIDTH = 3;
  localparam int unsigned RESP_BIT_WIDTH  = 2;

  typedef enum logic [STATE_BIT_WIDTH-1:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WR_B  = 3'd2,
    ST_RD_AR = 3'd3,
    ST_RD_R  = 3'd4,
    ST_RSP   = 3'd5
  } state_t;

  localparam logic [RESP_BIT_WIDTH-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_BIT_WIDTH-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [RESP_BIT_WIDTH-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_BIT_WIDTH-1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle with master and slave views.
interface axi4_lite_if #(
  parameter int unsigned ADDR_BIT_WIDTH = 32,
  parameter int unsigned DATA_BIT_WIDTH = 32
);

  localparam int unsigned STRB_BIT_WIDTH = DATA_BIT_WIDTH / 8;

  logic                      awvalid;
  logic                      awready;
  logic [ADDR_BIT_WIDTH-1:0] awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_BIT_WIDTH-1:0] wdata;
  logic [STRB_BIT_WIDTH-1:0] wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_BIT_WIDTH-1:0] araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_BIT_WIDTH-1:0] rdata;
  logic [1:0]                rresp;

  modport mst_port (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slv_port (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4_lite_cmd_mst.sv
// Single-outstanding command/response front end that issues AXI4-Lite reads and writes
// and reports the captured response and handshake latency.
module axi4_lite_cmd_mst
  import axi4_lite_cmd_mst_pkg::*;
#(
  parameter int unsigned ADDR_BIT_WIDTH    = 32,
  parameter int unsigned DATA_BIT_WIDTH    = 32,
  parameter int unsigned LAT_CNT_BIT_WIDTH = 16
) (
  input  logic                           i_clk,
  input  logic                           i_async_rst,
  input  logic                           i_cmd_valid,
  output logic                           o_cmd_ready,
  input  logic                           i_cmd_is_wr,
  input  logic [ADDR_BIT_WIDTH-1:0]      i_cmd_addr,
  input  logic [DATA_BIT_WIDTH-1:0]      i_cmd_wr_data,
  input  logic [DATA_BIT_WIDTH/8-1:0]    i_cmd_wr_strb,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic                           o_rsp_is_wr,
  output logic [DATA_BIT_WIDTH-1:0]      o_rsp_rd_data,
  output logic [RESP_BIT_WIDTH-1:0]      o_rsp_resp,
  output logic [LAT_CNT_BIT_WIDTH-1:0]   o_rsp_latency,
  axi4_lite_if.mst_port                  if_m_axi4_lite
);

  localparam int unsigned STRB_BIT_WIDTH = DATA_BIT_WIDTH / 8;

  // Only 32- and 64-bit data buses are supported.
  if (!(DATA_BIT_WIDTH == 32 || DATA_BIT_WIDTH == 64)) begin : g_bad_data_width
    $error("axi4_lite_cmd_mst: DATA_BIT_WIDTH must be 32 or 64");
  end

  typedef struct packed {
    logic                      is_wr;
    logic [ADDR_BIT_WIDTH-1:0] addr;
    logic [DATA_BIT_WIDTH-1:0] wr_data;
    logic [STRB_BIT_WIDTH-1:0] wr_strb;
  } cmd_t;

  state_t                       state_q;
  cmd_t                         cmd_q;
  logic                         awvalid_q;
  logic                         wvalid_q;
  logic                         arvalid_q;
  logic                         bready_q;
  logic                         rready_q;
  logic                         aw_done_q;
  logic                         w_done_q;
  logic [LAT_CNT_BIT_WIDTH-1:0] lat_q;
  logic                         rsp_valid_q;
  logic                         rsp_is_wr_q;
  logic [DATA_BIT_WIDTH-1:0]    rsp_rd_data_q;
  logic [RESP_BIT_WIDTH-1:0]    rsp_resp_q;
  logic [LAT_CNT_BIT_WIDTH-1:0] rsp_latency_q;

  logic                         aw_hs_c;
  logic                         w_hs_c;
  logic                         b_hs_c;
  logic                         ar_hs_c;
  logic                         r_hs_c;
  logic [LAT_CNT_BIT_WIDTH-1:0] lat_inc_c;

  assign aw_hs_c   = awvalid_q & if_m_axi4_lite.awready;
  assign w_hs_c    = wvalid_q  & if_m_axi4_lite.wready;
  assign b_hs_c    = bready_q  & if_m_axi4_lite.bvalid;
  assign ar_hs_c   = arvalid_q & if_m_axi4_lite.arready;
  assign r_hs_c    = rready_q  & if_m_axi4_lite.rvalid;
  // Latency value including the current cycle; the B/R capture takes this one.
  assign lat_inc_c = (&lat_q) ? lat_q : lat_q + LAT_CNT_BIT_WIDTH'(1);

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      lat_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_is_wr_q   <= 1'b0;
      rsp_rd_data_q <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_latency_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            cmd_q     <= '{is_wr:   i_cmd_is_wr,
                           addr:    i_cmd_addr,
                           wr_data: i_cmd_wr_data,
                           wr_strb: i_cmd_wr_strb};
            lat_q     <= LAT_CNT_BIT_WIDTH'(1);
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (i_cmd_is_wr) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_AR;
            end
          end
        end

        // AW and W complete independently, in either order or together.
        ST_WR: begin
          lat_q <= lat_inc_c;
          if (aw_hs_c) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs_c) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q | aw_hs_c) && (w_done_q | w_hs_c)) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_B;
          end
        end

        ST_WR_B: begin
          lat_q <= lat_inc_c;
          if (b_hs_c) begin
            bready_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_is_wr_q   <= cmd_q.is_wr;
            rsp_rd_data_q <= '0;
            rsp_resp_q    <= if_m_axi4_lite.bresp;
            rsp_latency_q <= lat_inc_c;
            state_q       <= ST_RSP;
          end
        end

        ST_RD_AR: begin
          lat_q <= lat_inc_c;
          if (ar_hs_c) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_R;
          end
        end

        ST_RD_R: begin
          lat_q <= lat_inc_c;
          if (r_hs_c) begin
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_is_wr_q   <= cmd_q.is_wr;
            rsp_rd_data_q <= if_m_axi4_lite.rdata;
            rsp_resp_q    <= if_m_axi4_lite.rresp;
            rsp_latency_q <= lat_inc_c;
            state_q       <= ST_RSP;
          end
        end

        ST_RSP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Ready decodes state only, so it reacts to reset without a clock edge.
  assign o_cmd_ready   = (state_q == ST_IDLE);
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_is_wr   = rsp_is_wr_q;
  assign o_rsp_rd_data = rsp_rd_data_q;
  assign o_rsp_resp    = rsp_resp_q;
  assign o_rsp_latency = rsp_latency_q;

  assign if_m_axi4_lite.awvalid = awvalid_q;
  assign if_m_axi4_lite.awaddr  = cmd_q.addr;
  assign if_m_axi4_lite.awprot  = 3'b000;
  assign if_m_axi4_lite.wvalid  = wvalid_q;
  assign if_m_axi4_lite.wdata   = cmd_q.wr_data;
  assign if_m_axi4_lite.wstrb   = cmd_q.wr_strb;
  assign if_m_axi4_lite.bready  = bready_q;
  assign if_m_axi4_lite.arvalid = arvalid_q;
  assign if_m_axi4_lite.araddr  = cmd_q.addr;
  assign if_m_axi4_lite.arprot  = 3'b000;
  assign if_m_axi4_lite.rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_cmd_mst.sv
// Directed bench for axi4_lite_cmd_mst with a small 16-word AXI4-Lite slave model.
module tb_axi4_lite_cmd_mst;

  logic        i_clk;
  logic        i_async_rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_is_wr;
  logic [31:0] i_cmd_addr;
  logic [31:0] i_cmd_wr_data;
  logic [3:0]  i_cmd_wr_strb;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic        o_rsp_is_wr;
  logic [31:0] o_rsp_rd_data;
  logic [1:0]  o_rsp_resp;
  logic [15:0] o_rsp_latency;

  int total = 0;
  int bad   = 0;

  axi4_lite_if #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) axi ();

  axi4_lite_cmd_mst #(
    .ADDR_BIT_WIDTH   (32),
    .DATA_BIT_WIDTH   (32),
    .LAT_CNT_BIT_WIDTH(16)
  ) dut (
    .i_clk         (i_clk),
    .i_async_rst   (i_async_rst),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_is_wr   (i_cmd_is_wr),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_wr_data (i_cmd_wr_data),
    .i_cmd_wr_strb (i_cmd_wr_strb),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_is_wr   (o_rsp_is_wr),
    .o_rsp_rd_data (o_rsp_rd_data),
    .o_rsp_resp    (o_rsp_resp),
    .o_rsp_latency (o_rsp_latency),
    .if_m_axi4_lite(axi)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- slave model ----------------
  logic [31:0] mem [16];
  int          w_dly;
  int          w_cnt;
  logic        r_stall;
  logic [1:0]  wr_resp_cfg;
  logic [1:0]  rd_resp_cfg;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_l, w_data_l;
  logic [3:0]  w_strb_l;
  logic        bvalid_q, r_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic        aw_hs, w_hs, have_aw, have_w;
  logic [31:0] wa, wd, merged;
  logic [3:0]  ws;

  assign axi.awready = 1'b1;
  assign axi.arready = 1'b1;
  assign axi.wready  = axi.wvalid && (w_cnt >= w_dly);
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.rvalid  = r_q & ~r_stall;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  assign aw_hs   = axi.awvalid & axi.awready;
  assign w_hs    = axi.wvalid & axi.wready;
  assign have_aw = aw_got | aw_hs;
  assign have_w  = w_got | w_hs;
  assign wa      = aw_hs ? axi.awaddr : aw_addr_l;
  assign wd      = w_hs ? axi.wdata : w_data_l;
  assign ws      = w_hs ? axi.wstrb : w_strb_l;

  always_comb begin
    merged = mem[wa[5:2]];
    for (int b = 0; b < 4; b++)
      if (ws[b]) merged[8*b +: 8] = wd[8*b +: 8];
  end

  always @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_l <= '0;
      w_data_l  <= '0;
      w_strb_l  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      r_q       <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      w_cnt     <= 0;
    end else begin
      w_cnt <= (axi.wvalid && !w_hs) ? w_cnt + 1 : 0;
      if (aw_hs) begin
        aw_got    <= 1'b1;
        aw_addr_l <= axi.awaddr;
      end
      if (w_hs) begin
        w_got    <= 1'b1;
        w_data_l <= axi.wdata;
        w_strb_l <= axi.wstrb;
      end
      if (have_aw && have_w && !bvalid_q) begin
        mem[wa[5:2]] <= merged;
        bvalid_q     <= 1'b1;
        bresp_q      <= wr_resp_cfg;
        aw_got       <= 1'b0;
        w_got        <= 1'b0;
      end
      if (bvalid_q && axi.bready) bvalid_q <= 1'b0;
      if (axi.arvalid && axi.arready) begin
        r_q     <= 1'b1;
        rdata_q <= mem[axi.araddr[5:2]];
        rresp_q <= rd_resp_cfg;
      end
      if (axi.rvalid && axi.rready) r_q <= 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    int n;
    i_cmd_is_wr   = wr;
    i_cmd_addr    = addr;
    i_cmd_wr_data = data;
    i_cmd_wr_strb = strb;
    i_cmd_valid   = 1'b1;
    n = 0;
    while (!o_cmd_ready && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("cmd_ready_timeout", 64'(o_cmd_ready), 64'd1);
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!o_rsp_valid && n < 100) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("rsp_valid_timeout", 64'(o_rsp_valid), 64'd1);
  endtask

  task automatic finish_rsp();
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
    chk("rsp_valid_drop", 64'(o_rsp_valid), 64'd0);
    chk("cmd_ready_back", 64'(o_cmd_ready), 64'd1);
  endtask

  function automatic logic [4:0] valids();
    return {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    i_async_rst   = 1'b1;
    i_cmd_valid   = 1'b0;
    i_cmd_is_wr   = 1'b0;
    i_cmd_addr    = '0;
    i_cmd_wr_data = '0;
    i_cmd_wr_strb = '0;
    i_rsp_ready   = 1'b0;
    w_dly         = 0;
    r_stall       = 1'b0;
    wr_resp_cfg   = 2'b00;
    rd_resp_cfg   = 2'b00;
    #22;
    i_async_rst = 1'b0;
    @(posedge i_clk); #1;

    // reset state
    chk("rst_cmd_ready", 64'(o_cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("rst_valids", 64'(valids()), 64'd0);
    chk("rst_awaddr", 64'(axi.awaddr), 64'd0);
    chk("rst_wdata", 64'(axi.wdata), 64'd0);
    chk("rst_wstrb", 64'(axi.wstrb), 64'd0);
    chk("rst_rsp_fields", {o_rsp_rd_data, 14'd0, o_rsp_resp, o_rsp_latency}, 64'd0);

    // zero-wait write
    issue(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
    chk("wr1_awvalid", 64'(axi.awvalid), 64'd1);
    chk("wr1_wvalid", 64'(axi.wvalid), 64'd1);
    chk("wr1_prot", 64'({axi.awprot, axi.arprot}), 64'd0);
    wait_rsp();
    chk("wr1_resp", 64'(o_rsp_resp), 64'd0);
    chk("wr1_is_wr", 64'(o_rsp_is_wr), 64'd1);
    chk("wr1_rd_data", 64'(o_rsp_rd_data), 64'd0);
    chk("wr1_latency", 64'(o_rsp_latency), 64'd3);
    chk("wr1_mem", 64'(mem[1]), 64'hDEAD_BEEF);
    finish_rsp();

    // read back
    issue(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    chk("rd1_arvalid", 64'(axi.arvalid), 64'd1);
    chk("rd1_araddr", 64'(axi.araddr), 64'h4);
    wait_rsp();
    chk("rd1_data", 64'(o_rsp_rd_data), 64'hDEAD_BEEF);
    chk("rd1_resp", 64'(o_rsp_resp), 64'd0);
    chk("rd1_is_wr", 64'(o_rsp_is_wr), 64'd0);
    chk("rd1_latency", 64'(o_rsp_latency), 64'd3);
    finish_rsp();

    // wready delayed 5 cycles after awready
    w_dly = 5;
    issue(1'b1, 32'h0000_0008, 32'h1234_5678, 4'hF);
    @(posedge i_clk); #1;
    chk("wr2_awvalid_dropped", 64'(axi.awvalid), 64'd0);
    chk("wr2_wvalid_held", 64'(axi.wvalid), 64'd1);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk("wr2_wvalid_still", 64'(axi.wvalid), 64'd1);
    chk("wr2_wdata_stable", 64'({axi.wstrb, axi.wdata}), 64'hF_1234_5678);
    wait_rsp();
    chk("wr2_resp", 64'(o_rsp_resp), 64'd0);
    chk("wr2_latency", 64'(o_rsp_latency), 64'd8);
    chk("wr2_mem", 64'(mem[2]), 64'h1234_5678);
    finish_rsp();
    w_dly = 0;

    // partial-strobe write then readback
    issue(1'b1, 32'h0000_0004, 32'h0000_AB00, 4'b0010);
    wait_rsp();
    chk("wr3_latency", 64'(o_rsp_latency), 64'd3);
    finish_rsp();
    issue(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    wait_rsp();
    chk("rd3_data", 64'(o_rsp_rd_data), 64'hDEAD_ABEF);
    finish_rsp();

    // SLVERR read response passes through
    rd_resp_cfg = 2'b10;
    issue(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    wait_rsp();
    chk("rd4_resp", 64'(o_rsp_resp), 64'h2);
    chk("rd4_data", 64'(o_rsp_rd_data), 64'h1234_5678);
    finish_rsp();
    rd_resp_cfg = 2'b00;

    // following write completes normally
    issue(1'b1, 32'h0000_000C, 32'hCAFE_F00D, 4'hF);
    wait_rsp();
    chk("wr5_resp", 64'(o_rsp_resp), 64'd0);
    chk("wr5_latency", 64'(o_rsp_latency), 64'd3);
    chk("wr5_mem", 64'(mem[3]), 64'hCAFE_F00D);
    finish_rsp();

    // response back-pressure for 10 cycles
    issue(1'b0, 32'h0000_000C, 32'h0, 4'h0);
    wait_rsp();
    for (int k = 0; k < 10; k++) begin
      @(posedge i_clk); #1;
      chk("hold_rsp_valid", 64'(o_rsp_valid), 64'd1);
      chk("hold_cmd_ready", 64'(o_cmd_ready), 64'd0);
      chk("hold_axi_idle", 64'(valids()), 64'd0);
      chk("hold_rd_data", 64'(o_rsp_rd_data), 64'hCAFE_F00D);
    end
    chk("hold_latency", 64'(o_rsp_latency), 64'd3);
    finish_rsp();

    // DECERR write response passes through
    wr_resp_cfg = 2'b11;
    issue(1'b1, 32'h0000_0010, 32'h0BAD_F00D, 4'hF);
    wait_rsp();
    chk("wr6_resp", 64'(o_rsp_resp), 64'h3);
    chk("wr6_is_wr", 64'(o_rsp_is_wr), 64'd1);
    finish_rsp();
    wr_resp_cfg = 2'b00;

    // async reset while waiting in the R phase
    r_stall = 1'b1;
    issue(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    @(posedge i_clk); #1;
    chk("rd7_in_r_phase", 64'({axi.arvalid, axi.rready}), 64'b01);
    chk("rd7_cmd_ready_busy", 64'(o_cmd_ready), 64'd0);
    #2;
    i_async_rst = 1'b1;
    #1;
    chk("arst_valids", 64'(valids()), 64'd0);
    chk("arst_cmd_ready", 64'(o_cmd_ready), 64'd1);
    chk("arst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    #2;
    i_async_rst = 1'b0;
    r_stall     = 1'b0;
    @(posedge i_clk); #1;
    chk("post_rst_idle", 64'({o_cmd_ready, o_rsp_valid}), 64'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
